// File: rtl/correlator_pkg.sv
// Shared types and helpers for the inner-lag correlator: FSM states, sample and
// accumulator containers, and the saturating accumulate used when INNER_CORR_SATURATE_EN is set.
package correlator_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    SWEEP,
    DUMP
  } corr_state_e;

  localparam int unsigned SAMPLE_MAX_W = 16;
  localparam int unsigned ACC_MAX_W    = 64;

  typedef struct packed {
    logic signed [SAMPLE_MAX_W-1:0] i;
    logic signed [SAMPLE_MAX_W-1:0] q;
  } cplx_t;

  typedef struct packed {
    logic signed [ACC_MAX_W-1:0] cos;
    logic signed [ACC_MAX_W-1:0] sin;
  } acc_pair_t;

  // Operands arrive sign-extended to ACC_MAX_W; w must stay at or below ACC_MAX_W-2.
  function automatic logic signed [ACC_MAX_W-1:0] sat_add(
    input logic signed [ACC_MAX_W-1:0] a,
    input logic signed [ACC_MAX_W-1:0] b,
    input int unsigned                 w
  );
    logic signed [ACC_MAX_W-1:0] s, mx, mn;
    s  = a + b;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (w - 1));
    if (s > mx)      return mx;
    else if (s < mn) return mn;
    else             return s;
  endfunction

endpackage

// File: rtl/lag_accum_ram.sv
// Per-lag {cos, sin} accumulator storage: one synchronous read port, one write port, no reset.
// A read and write to the same address in one cycle returns the old contents.
module lag_accum_ram #(
  parameter int unsigned DEPTH = 12,
  parameter int unsigned DW    = 48,
  parameter int unsigned AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/inner_lag_correlator.sv
// Per-frame complex autocorrelation R[k] = sum x[n]*conj(x[n-k]) for k = 0..LAGS-1.
// Define INNER_CORR_SATURATE_EN for saturating accumulators; otherwise they wrap.
module inner_lag_correlator
  import correlator_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ACCUM = 24,
  parameter int unsigned LAGS  = 12
) (
  input  logic                    clock_x,
  input  logic                    reset_xn,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    tlast_i,
  input  logic signed [WIDTH-1:0] dat_i_i,
  input  logic signed [WIDTH-1:0] dat_q_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    tlast_o,
  output logic signed [ACCUM-1:0] dat_cos_o,
  output logic signed [ACCUM-1:0] dat_sin_o
);

  localparam int unsigned   AW   = (LAGS > 1) ? $clog2(LAGS) : 1;
  localparam int unsigned   PW   = 2 * WIDTH + 1;
  localparam logic [AW-1:0] LAST = AW'(LAGS - 1);

  corr_state_e state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, addr_q, addr_d, ptr_nxt;
  logic pend_q, pend_d, last_q, last_d;
  logic signed [WIDTH-1:0] hist_i_q [LAGS];
  logic signed [WIDTH-1:0] hist_i_d [LAGS];
  logic signed [WIDTH-1:0] hist_q_q [LAGS];
  logic signed [WIDTH-1:0] hist_q_d [LAGS];
  logic valid_q, valid_d, tlast_q, tlast_d;
  logic signed [ACCUM-1:0] cos_q, cos_d, sin_q, sin_d;

  logic                    ram_we;
  logic [AW-1:0]           ram_waddr;
  logic [2*ACCUM-1:0]      ram_wdata, ram_rdata;
  logic signed [ACCUM-1:0] rd_cos, rd_sin, new_cos, new_sin;
  logic signed [PW-1:0]    xi, xq, ki, kq, prod_c, prod_s;

  lag_accum_ram #(.DEPTH(LAGS), .DW(2 * ACCUM), .AW(AW)) u_ram (
    .clk_i  (clock_x),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(ptr_q),
    .rdata_o(ram_rdata)
  );

  assign rd_cos  = ram_rdata[2*ACCUM-1:ACCUM];
  assign rd_sin  = ram_rdata[ACCUM-1:0];
  assign ptr_nxt = (ptr_q == LAST) ? '0 : ptr_q + AW'(1);

  // Products for the lag whose stored sum returned from the RAM this cycle.
  assign xi     = PW'(hist_i_q[0]);
  assign xq     = PW'(hist_q_q[0]);
  assign ki     = PW'(hist_i_q[addr_q]);
  assign kq     = PW'(hist_q_q[addr_q]);
  assign prod_c = xi * ki + xq * kq;
  assign prod_s = xq * ki - xi * kq;

`ifdef INNER_CORR_SATURATE_EN
  acc_pair_t acc_ext, prod_ext;
  always_comb begin
    acc_ext.cos  = ACC_MAX_W'(rd_cos);
    acc_ext.sin  = ACC_MAX_W'(rd_sin);
    prod_ext.cos = ACC_MAX_W'(prod_c);
    prod_ext.sin = ACC_MAX_W'(prod_s);
  end
  assign new_cos = ACCUM'(sat_add(acc_ext.cos, prod_ext.cos, ACCUM));
  assign new_sin = ACCUM'(sat_add(acc_ext.sin, prod_ext.sin, ACCUM));
`else
  assign new_cos = rd_cos + ACCUM'(prod_c);
  assign new_sin = rd_sin + ACCUM'(prod_s);
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    pend_d    = 1'b0;
    last_d    = last_q;
    hist_i_d  = hist_i_q;
    hist_q_d  = hist_q_q;
    valid_d   = valid_q;
    tlast_d   = tlast_q;
    cos_d     = cos_q;
    sin_d     = sin_q;
    ram_we    = 1'b0;
    ram_waddr = addr_q;
    ram_wdata = '0;
    unique case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = ptr_q;
        ptr_d     = ptr_nxt;
        if (ptr_q == LAST) state_d = IDLE;
      end
      IDLE: begin
        if (valid_i) begin
          for (int unsigned k = 1; k < LAGS; k++) begin
            hist_i_d[k] = hist_i_q[k-1];
            hist_q_d[k] = hist_q_q[k-1];
          end
          hist_i_d[0] = dat_i_i;
          hist_q_d[0] = dat_q_i;
          last_d      = tlast_i;
          state_d     = SWEEP;
        end
      end
      SWEEP: begin
        // Read lag ptr, write it back one cycle later; pend with ptr back at 0 is the final write.
        if (pend_q) begin
          ram_we    = 1'b1;
          ram_wdata = {new_cos, new_sin};
        end
        if (pend_q && ptr_q == '0) begin
          if (last_q) begin
            state_d  = DUMP;
            hist_i_d = '{default: '0};
            hist_q_d = '{default: '0};
          end else begin
            state_d = IDLE;
          end
        end else begin
          pend_d = 1'b1;
          addr_d = ptr_q;
          ptr_d  = ptr_nxt;
        end
      end
      DUMP: begin
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          tlast_d = 1'b0;
          if (tlast_q) state_d = IDLE;
        end
        if (pend_q) begin
          valid_d = 1'b1;
          tlast_d = (addr_q == LAST);
          cos_d   = rd_cos;
          sin_d   = rd_sin;
        end
        if (!pend_q && (!valid_q || (ready_i && !tlast_q))) begin
          pend_d    = 1'b1;
          addr_d    = ptr_q;
          ptr_d     = ptr_nxt;
          ram_we    = 1'b1;
          ram_waddr = ptr_q;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clock_x or negedge reset_xn) begin
    if (!reset_xn) begin
      state_q  <= CLEAR;
      ptr_q    <= '0;
      addr_q   <= '0;
      pend_q   <= 1'b0;
      last_q   <= 1'b0;
      hist_i_q <= '{default: '0};
      hist_q_q <= '{default: '0};
      valid_q  <= 1'b0;
      tlast_q  <= 1'b0;
      cos_q    <= '0;
      sin_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      pend_q   <= pend_d;
      last_q   <= last_d;
      hist_i_q <= hist_i_d;
      hist_q_q <= hist_q_d;
      valid_q  <= valid_d;
      tlast_q  <= tlast_d;
      cos_q    <= cos_d;
      sin_q    <= sin_d;
    end
  end

  assign ready_o   = (state_q == IDLE);
  assign valid_o   = valid_q;
  assign tlast_o   = tlast_q;
  assign dat_cos_o = cos_q;
  assign dat_sin_o = sin_q;

endmodule

// File: tb/tb_inner_lag_correlator.sv
// Scoreboard bench for inner_lag_correlator (LAGS=4, ACCUM=16 main instance, ACCUM=8 overflow instance).
module tb_inner_lag_correlator;
  import correlator_pkg::*;

  localparam int unsigned LAGS = 4;

  logic clock_x  = 1'b0;
  logic reset_xn = 1'b0;
  always #5 clock_x = ~clock_x;

  logic valid_i = 1'b0, tlast_i = 1'b0, ready_i = 1'b0;
  logic signed [3:0] dat_i_i = '0, dat_q_i = '0;
  logic ready_o, valid_o, tlast_o;
  logic signed [15:0] dat_cos_o, dat_sin_o;

  logic valid8_i = 1'b0, tlast8_i = 1'b0, ready8_i = 1'b0;
  logic signed [3:0] dat_i8_i = '0, dat_q8_i = '0;
  logic ready8_o, valid8_o, tlast8_o;
  logic signed [7:0] dat_cos8_o, dat_sin8_o;

  inner_lag_correlator #(.WIDTH(4), .ACCUM(16), .LAGS(LAGS)) dut (
    .clock_x(clock_x), .reset_xn(reset_xn), .valid_i(valid_i), .ready_o(ready_o),
    .tlast_i(tlast_i), .dat_i_i(dat_i_i), .dat_q_i(dat_q_i), .valid_o(valid_o),
    .ready_i(ready_i), .tlast_o(tlast_o), .dat_cos_o(dat_cos_o), .dat_sin_o(dat_sin_o)
  );

  inner_lag_correlator #(.WIDTH(4), .ACCUM(8), .LAGS(LAGS)) dut8 (
    .clock_x(clock_x), .reset_xn(reset_xn), .valid_i(valid8_i), .ready_o(ready8_o),
    .tlast_i(tlast8_i), .dat_i_i(dat_i8_i), .dat_q_i(dat_q8_i), .valid_o(valid8_o),
    .ready_i(ready8_i), .tlast_o(tlast8_o), .dat_cos_o(dat_cos8_o), .dat_sin_o(dat_sin8_o)
  );

  typedef struct { int c; int s; bit l; } beat_t;
  beat_t sb[$];
  int unsigned n_cmp = 0, n_bad = 0;

  function automatic cplx_t mk(input int i, input int q);
    cplx_t r;
    r.i = 16'(i);
    r.q = 16'(q);
    return r;
  endfunction

  // Reference correlation straight from the definition, zero history before frame start.
  function automatic void push_expected(input cplx_t f[$]);
    for (int k = 0; k < int'(LAGS); k++) begin
      beat_t b;
      b.c = 0;
      b.s = 0;
      for (int n = k; n < f.size(); n++) begin
        b.c += int'(f[n].i) * int'(f[n-k].i) + int'(f[n].q) * int'(f[n-k].q);
        b.s += int'(f[n].q) * int'(f[n-k].i) - int'(f[n].i) * int'(f[n-k].q);
      end
      b.l = (k == int'(LAGS) - 1);
      sb.push_back(b);
    end
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? ready8_o : ready_o;
  endfunction

  function automatic logic vld(input bit sel);
    return sel ? valid8_o : valid_o;
  endfunction

  // valid stays high between samples of a frame so a non-IDLE transfer would corrupt results.
  task automatic send_sample(input bit sel, input cplx_t x, input bit last, output int lat, output bit to);
    int n = 0;
    to  = 1'b0;
    lat = 0;
    if (sel) begin valid8_i = 1'b1; dat_i8_i = x.i[3:0]; dat_q8_i = x.q[3:0]; tlast8_i = last; end
    else     begin valid_i  = 1'b1; dat_i_i  = x.i[3:0]; dat_q_i  = x.q[3:0]; tlast_i  = last; end
    while (rdy(sel) !== 1'b1 && n < 300) begin @(posedge clock_x); #1; n++; end
    if (rdy(sel) !== 1'b1) begin
      to = 1'b1;
      if (sel) valid8_i = 1'b0; else valid_i = 1'b0;
      return;
    end
    @(posedge clock_x); #1;
    if (last) begin
      if (sel) begin valid8_i = 1'b0; tlast8_i = 1'b0; end
      else     begin valid_i  = 1'b0; tlast_i  = 1'b0; end
    end else begin
      while (rdy(sel) !== 1'b1 && lat < 100) begin @(posedge clock_x); #1; lat++; end
    end
  endtask

  task automatic send_frame(input bit sel, input cplx_t f[$], output int lmin, output int lmax, output bit to);
    int lat;
    bit t;
    lmin = 1000;
    lmax = -1;
    to   = 1'b0;
    if (!sel) push_expected(f);
    for (int n = 0; n < f.size(); n++) begin
      send_sample(sel, f[n], n == f.size() - 1, lat, t);
      to |= t;
      if (n != f.size() - 1) begin
        if (lat < lmin) lmin = lat;
        if (lat > lmax) lmax = lat;
      end
    end
  endtask

  task automatic get_beat(input bit sel, output int c, output int s, output bit l, output bit to);
    int n = 0;
    to = 1'b0;
    c  = 0;
    s  = 0;
    l  = 1'b0;
    if (sel) ready8_i = 1'b1; else ready_i = 1'b1;
    while (vld(sel) !== 1'b1 && n < 200) begin @(posedge clock_x); #1; n++; end
    if (vld(sel) !== 1'b1) to = 1'b1;
    else begin
      c = sel ? int'(dat_cos8_o) : int'(dat_cos_o);
      s = sel ? int'(dat_sin8_o) : int'(dat_sin_o);
      l = sel ? tlast8_o : tlast_o;
      @(posedge clock_x); #1;
    end
    if (sel) ready8_i = 1'b0; else ready_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock_x);
    #1;
    n_cmp += 5;
    if (valid_o !== 1'b0)  begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    if (tlast_o !== 1'b0)  begin n_bad++; $display("FAIL rst_tlast: got %b want 0", tlast_o); end
    if (ready_o !== 1'b0)  begin n_bad++; $display("FAIL rst_ready: got %b want 0", ready_o); end
    if (dat_cos_o !== '0)  begin n_bad++; $display("FAIL rst_cos: got %0d want 0", dat_cos_o); end
    if (dat_sin_o !== '0)  begin n_bad++; $display("FAIL rst_sin: got %0d want 0", dat_sin_o); end
    reset_xn = 1'b1;
    for (int c = 1; c < int'(LAGS); c++) begin
      @(posedge clock_x); #1;
      n_cmp += 2;
      if (ready_o !== 1'b0) begin n_bad++; $display("FAIL clear_ready c%0d: got %b want 0", c, ready_o); end
      if (valid_o !== 1'b0) begin n_bad++; $display("FAIL clear_valid c%0d: got %b want 0", c, valid_o); end
    end
    @(posedge clock_x); #1;
    n_cmp += 2;
    if (ready_o !== 1'b1) begin n_bad++; $display("FAIL clear_done_ready: got %b want 1", ready_o); end
    if (valid_o !== 1'b0) begin n_bad++; $display("FAIL clear_done_valid: got %b want 0", valid_o); end
  endtask

  task automatic test_ramp();
    cplx_t f[$];
    int lmin, lmax, c, s;
    bit to, l;
    beat_t e;
    for (int n = 0; n < 8; n++) f.push_back(mk(1, 0));
    send_frame(1'b0, f, lmin, lmax, to);
    n_cmp += 3;
    if (to !== 1'b0) begin n_bad++; $display("FAIL ramp_send_timeout: got %b want 0", to); end
    if (lmin != int'(LAGS) + 1) begin n_bad++; $display("FAIL ramp_ready_lat_min: got %0d want %0d", lmin, LAGS + 1); end
    if (lmax != int'(LAGS) + 1) begin n_bad++; $display("FAIL ramp_ready_lat_max: got %0d want %0d", lmax, LAGS + 1); end
    for (int k = 0; k < int'(LAGS); k++) begin
      get_beat(1'b0, c, s, l, to);
      e = sb.pop_front();
      n_cmp += 4;
      if (to !== 1'b0) begin n_bad++; $display("FAIL ramp_beat_timeout k%0d: got %b want 0", k, to); end
      if (c != e.c)    begin n_bad++; $display("FAIL ramp_cos k%0d: got %0d want %0d", k, c, e.c); end
      if (s != e.s)    begin n_bad++; $display("FAIL ramp_sin k%0d: got %0d want %0d", k, s, e.s); end
      if (l !== e.l)   begin n_bad++; $display("FAIL ramp_tlast k%0d: got %b want %b", k, l, e.l); end
    end
  endtask

  task automatic test_rotation();
    cplx_t f[$];
    int lmin, lmax, c, s;
    bit to, l;
    beat_t e;
    f = '{mk(1, 0), mk(0, 1), mk(-1, 0), mk(0, -1)};
    send_frame(1'b0, f, lmin, lmax, to);
    n_cmp += 1;
    if (to !== 1'b0) begin n_bad++; $display("FAIL rot_send_timeout: got %b want 0", to); end
    for (int k = 0; k < int'(LAGS); k++) begin
      get_beat(1'b0, c, s, l, to);
      e = sb.pop_front();
      n_cmp += 3;
      if (c != e.c)  begin n_bad++; $display("FAIL rot_cos k%0d: got %0d want %0d", k, c, e.c); end
      if (s != e.s)  begin n_bad++; $display("FAIL rot_sin k%0d: got %0d want %0d", k, s, e.s); end
      if (l !== e.l) begin n_bad++; $display("FAIL rot_tlast k%0d: got %b want %b", k, l, e.l); end
    end
  endtask

  task automatic test_backpressure();
    cplx_t f[$];
    int lmin, lmax, c, s, n;
    bit to, l;
    beat_t e;
    f = '{mk(1, 0), mk(0, 1), mk(-1, 0), mk(0, -1)};
    for (int rep = 0; rep < 2; rep++) begin
      send_frame(1'b0, f, lmin, lmax, to);
      for (int k = 0; k < int'(LAGS); k++) begin
        if (rep == 0 && k == 1) begin
          n = 0;
          while (valid_o !== 1'b1 && n < 50) begin @(posedge clock_x); #1; n++; end
          e = sb[0];
          for (int h = 0; h < 5; h++) begin
            @(posedge clock_x); #1;
            n_cmp += 3;
            if (valid_o !== 1'b1)       begin n_bad++; $display("FAIL bp_hold_valid h%0d: got %b want 1", h, valid_o); end
            if (int'(dat_cos_o) != e.c) begin n_bad++; $display("FAIL bp_hold_cos h%0d: got %0d want %0d", h, dat_cos_o, e.c); end
            if (int'(dat_sin_o) != e.s) begin n_bad++; $display("FAIL bp_hold_sin h%0d: got %0d want %0d", h, dat_sin_o, e.s); end
          end
        end
        get_beat(1'b0, c, s, l, to);
        e = sb.pop_front();
        n_cmp += 4;
        if (to !== 1'b0) begin n_bad++; $display("FAIL bp_timeout r%0d k%0d: got %b want 0", rep, k, to); end
        if (c != e.c)    begin n_bad++; $display("FAIL bp_cos r%0d k%0d: got %0d want %0d", rep, k, c, e.c); end
        if (s != e.s)    begin n_bad++; $display("FAIL bp_sin r%0d k%0d: got %0d want %0d", rep, k, s, e.s); end
        if (l !== e.l)   begin n_bad++; $display("FAIL bp_tlast r%0d k%0d: got %b want %b", rep, k, l, e.l); end
      end
    end
  endtask

  task automatic test_saturate();
    cplx_t f[$];
    int lmin, lmax, c, s, exp_c;
    bit to, l;
`ifdef INNER_CORR_SATURATE_EN
    exp_c = 127;
`else
    exp_c = -44;
`endif
    for (int n = 0; n < 10; n++) f.push_back(mk(7, 7));
    send_frame(1'b1, f, lmin, lmax, to);
    for (int k = 0; k < int'(LAGS); k++) begin
      get_beat(1'b1, c, s, l, to);
      n_cmp += 2;
      if (to !== 1'b0) begin n_bad++; $display("FAIL sat_timeout k%0d: got %b want 0", k, to); end
      if (l !== (k == int'(LAGS) - 1)) begin n_bad++; $display("FAIL sat_tlast k%0d: got %b want %b", k, l, k == int'(LAGS) - 1); end
      if (k == 0) begin
        n_cmp += 2;
        if (c != exp_c) begin n_bad++; $display("FAIL sat_cos0: got %0d want %0d", c, exp_c); end
        if (s != 0)     begin n_bad++; $display("FAIL sat_sin0: got %0d want 0", s); end
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    cplx_t f[$];
    int lmin, lmax, c, s, n;
    bit to, l;
    beat_t e;
    for (int i = 0; i < 8; i++) f.push_back(mk(1, 0));
    send_frame(1'b0, f, lmin, lmax, to);
    get_beat(1'b0, c, s, l, to);
    e = sb.pop_front();
    n_cmp += 1;
    if (c != e.c) begin n_bad++; $display("FAIL rmd_first_cos: got %0d want %0d", c, e.c); end
    n = 0;
    while (valid_o !== 1'b1 && n < 50) begin @(posedge clock_x); #1; n++; end
    reset_xn = 1'b0;
    #1;
    n_cmp += 2;
    if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rmd_valid_drop: got %b want 0", valid_o); end
    if (ready_o !== 1'b0) begin n_bad++; $display("FAIL rmd_ready_low: got %b want 0", ready_o); end
    sb.delete();
    @(posedge clock_x); #1;
    reset_xn = 1'b1;
    send_frame(1'b0, f, lmin, lmax, to);
    n_cmp += 1;
    if (to !== 1'b0) begin n_bad++; $display("FAIL rmd_send_timeout: got %b want 0", to); end
    for (int k = 0; k < int'(LAGS); k++) begin
      get_beat(1'b0, c, s, l, to);
      e = sb.pop_front();
      n_cmp += 3;
      if (c != e.c)  begin n_bad++; $display("FAIL rmd_cos k%0d: got %0d want %0d", k, c, e.c); end
      if (s != e.s)  begin n_bad++; $display("FAIL rmd_sin k%0d: got %0d want %0d", k, s, e.s); end
      if (l !== e.l) begin n_bad++; $display("FAIL rmd_tlast k%0d: got %b want %b", k, l, e.l); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_rotation();
    test_backpressure();
    test_saturate();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inner_lag_correlator.md
INNER_LAG_CORRELATOR -- requirements
Module: inner_lag_correlator

Interface
REQ-001 Parameter WIDTH, default 4: signed bit width of each input I and Q sample.
REQ-002 Parameter ACCUM, default 24: signed bit width of each cos and sin accumulator and output.
REQ-003 Parameter LAGS, default 12: number of correlation lags k = 0..LAGS-1, minimum 2.
REQ-004 Port clock_x, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset_xn, input, 1 bit: asynchronous, active-low reset.
REQ-006 Ports valid_i (in, 1) and ready_o (out, 1): input handshake; a sample transfers when both are high at a clock edge.
REQ-007 Port tlast_i, input, 1 bit: marks the final sample of an integration frame.
REQ-008 Ports dat_i_i and dat_q_i, input, WIDTH bits each: signed in-phase and quadrature sample.
REQ-009 Ports valid_o (out, 1) and ready_i (in, 1): output handshake; a beat transfers when both are high.
REQ-010 Port tlast_o, output, 1 bit: marks the lag LAGS-1 beat.
REQ-011 Ports dat_cos_o and dat_sin_o, output, ACCUM bits each: signed real and imaginary correlation result.

Function
REQ-012 The block SHALL compute, per frame, R[k] = sum over n of x[n]*conj(x[n-k]), with x = I + jQ.
- cos += I[n]*I[n-k] + Q[n]*Q[n-k]
- sin += Q[n]*I[n-k] - I[n]*Q[n-k]
REQ-013 The history x[n-k] SHALL read as zero for samples before the frame start, and history SHALL be cleared at each frame end.
REQ-014 FSM states SHALL be CLEAR, IDLE, SWEEP and DUMP.
REQ-015 ready_o SHALL be high only in IDLE.
REQ-016 In CLEAR, the block SHALL zero one accumulator entry per cycle for LAGS cycles, then go to IDLE.
REQ-017 On an input transfer in IDLE, the block SHALL go to SWEEP and update lag 0..LAGS-1, one lag per cycle.
- ready_o returns high LAGS+1 cycles after the transfer when tlast_i was low.
REQ-018 If the transferred sample had tlast_i high, the block SHALL go to DUMP after the sweep completes.
REQ-019 In DUMP, the block SHALL present lags 0..LAGS-1 in order, one per output transfer.
- tlast_o is high only on lag LAGS-1.
- Each entry is zeroed as it is read.
- The block returns to IDLE after the final transfer.
REQ-020 valid_o, tlast_o and the data outputs SHALL be registered and held stable while valid_o=1 and ready_i=0.
- No beat is dropped or repeated.
REQ-021 Each product SHALL be formed at 2*WIDTH+1 bits and sign-extended to ACCUM before accumulation.
REQ-022 The accumulator memory pointer SHALL wrap from LAGS-1 to 0.
REQ-023 valid_i held high outside IDLE SHALL NOT transfer.
- The input is sampled only at an IDLE transfer.

Reset
REQ-024 While reset_xn=0, outputs SHALL be: valid_o=0, tlast_o=0, ready_o=0, dat_cos_o=0, dat_sin_o=0.
REQ-025 While reset_xn=0, the FSM SHALL be in CLEAR with pointer 0 and history cleared.
REQ-026 Reset asserted mid-SWEEP or mid-DUMP SHALL abort the frame.
- After release, the CLEAR pass zeroes all partial sums before ready_o rises.

Configuration
REQ-027 Macro INNER_CORR_SATURATE_EN SHALL select the accumulator overflow behaviour.
- Defined: each accumulator saturates at +(2^(ACCUM-1)-1) and -2^(ACCUM-1).
- Undefined: each accumulator wraps modulo 2^ACCUM.

Structure
REQ-028 Package correlator_pkg SHALL hold:
- the FSM state enumeration;
- the complex-sample and accumulator-pair typedefs;
- the saturating-add function.
REQ-029 Accumulator storage SHALL be sub-module lag_accum_ram: LAGS x 2*ACCUM, one read port plus one write port, no reset.

Verification (WIDTH=4, ACCUM=16, LAGS=4 unless stated)
REQ-030 Release reset.
- CLEAR lasts 4 cycles: ready_o=0, then ready_o=1.
- valid_o=0 throughout.
REQ-031 Send 8 samples of (I=1, Q=0), tlast on the 8th.
- Dump gives cos = 8, 7, 6, 5 and sin = 0, with tlast_o on the 4th beat.
REQ-032 Send (1,0), (0,1), (-1,0), (0,-1), tlast on the 4th.
- lag0: cos=4, sin=0.
- lag1: cos=0, sin=3.
- lag2: cos=-2, sin=0.
- lag3: cos=0, sin=-1.
REQ-033 Hold ready_i=0 for 5 cycles in mid-dump.
- valid_o stays 1 with data stable.
- All 4 lags arrive in order.
- A following identical frame gives identical results.
REQ-034 With ACCUM=8, send 10 samples of (7,7), tlast on the 10th.
- lag0 cos=127 with INNER_CORR_SATURATE_EN defined.
- lag0 cos=-44 without it.
REQ-035 Drop reset_xn during DUMP beat 2.
- valid_o falls immediately.
- After release and CLEAR, the REQ-031 stimulus reproduces 8, 7, 6, 5 exactly.
